// File: rtl/ahb_lite_master_if.sv
// Request/response handshake plus AHB-Lite master bus, bundled so the master and
// the bench or slave model see the same signal set.
interface ahb_lite_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // Handshake rules:
    //   Request:  a request transfers on the rising HCLK edge where req_valid and req_ready are both 1.
    //             req_ready is 1 only while the master is idle.
    //             req_write, req_size, req_addr and req_wdata are sampled on that edge only.
    //   Response: rsp_valid is a one-cycle pulse that carries rsp_rdata and rsp_err.
    //             There is no response backpressure.
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [1:0]            req_size;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    logic [ADDR_WIDTH-1:0] HADDR;
    logic [1:0]            HTRANS;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [DATA_WIDTH-1:0] HWDATA;
    logic                  HREADY;
    logic [DATA_WIDTH-1:0] HRDATA;
    logic                  HRESP;

    modport master (
        input  req_valid, req_write, req_size, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
        input  HREADY, HRDATA, HRESP
    );

    modport slave (
        output req_valid, req_write, req_size, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
        output HREADY, HRDATA, HRESP
    );
endinterface

// File: rtl/ahb_lite_master.sv
// Single-outstanding AHB-Lite master: turns one request into one SINGLE transfer
// and returns a one-cycle response pulse; misaligned or size-3 requests error locally.
module ahb_lite_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    ahb_lite_master_if.master    bus,
    output logic [1:0]           dbg_state
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [2:0] BURST_SINGLE = 3'b000;

    state_t                state;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  req_legal;
    logic [DATA_WIDTH-1:0] wdata_lanes;
    logic [DATA_WIDTH-1:0] rdata_shifted;
    logic [DATA_WIDTH-1:0] rdata_ext;

    assign dbg_state = state;

    always_comb begin
        req_legal = 1'b1;
        case (bus.req_size)
            2'd0:    req_legal = 1'b1;
            2'd1:    req_legal = ~bus.req_addr[0];
            2'd2:    req_legal = (bus.req_addr[1:0] == 2'b00);
            default: req_legal = 1'b0;
        endcase
    end

    // HADDR/HSIZE/HWRITE hold the latched request after the address phase,
    // so they also steer lane replication and read extraction.
    always_comb begin
        wdata_lanes = wdata_q;
        case (bus.HSIZE[1:0])
            2'd0:    wdata_lanes = {4{wdata_q[7:0]}};
            2'd1:    wdata_lanes = {2{wdata_q[15:0]}};
            default: wdata_lanes = wdata_q;
        endcase
    end

    always_comb begin
        rdata_shifted = bus.HRDATA >> {bus.HADDR[1:0], 3'b000};
        rdata_ext     = rdata_shifted;
        case (bus.HSIZE[1:0])
            2'd0:    rdata_ext = {24'h0, rdata_shifted[7:0]};
            2'd1:    rdata_ext = {16'h0, rdata_shifted[15:0]};
            default: rdata_ext = rdata_shifted;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state         <= IDLE;
            wdata_q       <= '0;
            bus.req_ready <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
            bus.HADDR     <= '0;
            bus.HTRANS    <= TRANS_IDLE;
            bus.HWRITE    <= 1'b0;
            bus.HSIZE     <= 3'b000;
            bus.HBURST    <= BURST_SINGLE;
            bus.HWDATA    <= '0;
        end else begin
            bus.rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid && bus.req_ready) begin
                        bus.req_ready <= 1'b0;
                        if (req_legal) begin
                            wdata_q    <= bus.req_wdata;
                            bus.HADDR  <= bus.req_addr;
                            bus.HWRITE <= bus.req_write;
                            bus.HSIZE  <= {1'b0, bus.req_size};
                            bus.HBURST <= BURST_SINGLE;
                            bus.HTRANS <= TRANS_NONSEQ;
                            state      <= ADDR;
                        end else begin
                            // Rejected locally: nothing reaches the bus.
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_err   <= 1'b1;
                            bus.rsp_rdata <= '0;
                            state         <= RESP;
                        end
                    end else begin
                        bus.req_ready <= 1'b1;
                    end
                end
                ADDR: begin
                    if (bus.HREADY) begin
                        bus.HTRANS <= TRANS_IDLE;
                        if (bus.HWRITE) begin
                            bus.HWDATA <= wdata_lanes;
                        end
                        state <= DATA;
                    end
                end
                DATA: begin
                    // An error's first (HREADY=0) cycle is just another wait state.
                    if (bus.HREADY) begin
                        bus.rsp_err   <= bus.HRESP;
                        bus.rsp_rdata <= bus.HWRITE ? '0 : rdata_ext;
                        bus.rsp_valid <= 1'b1;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    bus.req_ready <= 1'b1;
                    state         <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master: tasks drive requests and a slave model,
// and a monitor matches every rsp_valid pulse against the expected-response queue.
module tb_ahb_lite_master;
    logic       HCLK = 1'b0;
    logic       HRESET;
    logic [1:0] dbg_state;

    always #5 HCLK = ~HCLK;

    ahb_lite_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    ahb_lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    logic [32:0] exp_q[$];
    int n_cmp    = 0;
    int n_fail   = 0;
    int n_pushed = 0;
    int n_pulses = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Monitor: every response pulse must match the oldest queued expectation.
    always @(negedge HCLK) begin : monitor
        logic [32:0] e;
        if (HRESET !== 1'b1 && bus.rsp_valid === 1'b1) begin
            n_pulses++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 err=%b rdata=%h, required no response",
                         bus.rsp_err, bus.rsp_rdata);
            end else begin
                e = exp_q.pop_front();
                check("rsp_err_rdata", {31'h0, bus.rsp_err, bus.rsp_rdata}, {31'h0, e});
            end
        end
    end

    task automatic wait_ready();
        int t = 0;
        while (bus.req_ready !== 1'b1 && t < 20) begin
            @(negedge HCLK);
            t++;
        end
        check("req_ready_wait", bus.req_ready, 1'b1);
    endtask

    task automatic drive_req(input logic w, input logic [1:0] sz, input logic [31:0] a,
                             input logic [31:0] wd);
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_size  = sz;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        @(negedge HCLK);
        // Scramble the request so only the latched copy can produce correct results.
        bus.req_valid = 1'b0;
        bus.req_write = ~w;
        bus.req_size  = 2'd3;
        bus.req_addr  = 32'hFFFF_FFFF;
        bus.req_wdata = 32'h0;
    endtask

    task automatic xfer(input logic w, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input int aw, input int dw,
                        input logic [31:0] slave_rd, input logic slave_err, input logic legal,
                        input logic [31:0] exp_hw, input logic [31:0] exp_rd, input logic exp_err);
        wait_ready();
        exp_q.push_back({exp_err, exp_rd});
        n_pushed++;
        drive_req(w, sz, a, wd);
        if (!legal) begin
            check("htrans_illegal", bus.HTRANS, 2'b00);
            check("rsp_valid_illegal", bus.rsp_valid, 1'b1);
        end else begin
            for (int i = 0; i <= aw; i++) begin
                check("htrans_addr", bus.HTRANS, 2'b10);
                check("haddr", bus.HADDR, a);
                check("hwrite", bus.HWRITE, w);
                check("hsize", bus.HSIZE, {1'b0, sz});
                check("hburst", bus.HBURST, 3'b000);
                bus.HREADY = (i == aw);
                @(negedge HCLK);
            end
            bus.HRDATA = slave_rd;
            for (int i = 0; i <= dw; i++) begin
                check("htrans_data", bus.HTRANS, 2'b00);
                check("rsp_valid_early", bus.rsp_valid, 1'b0);
                if (w) check("hwdata", bus.HWDATA, exp_hw);
                bus.HREADY = (i == dw);
                bus.HRESP  = slave_err && (i >= dw - 1);
                @(negedge HCLK);
            end
            check("rsp_valid_resp", bus.rsp_valid, 1'b1);
            check("htrans_resp", bus.HTRANS, 2'b00);
            bus.HREADY = 1'b1;
            bus.HRESP  = 1'b0;
        end
        @(negedge HCLK);
        check("htrans_after", bus.HTRANS, 2'b00);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        HRESET        = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_size  = 2'd0;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;
        bus.HREADY    = 1'b1;
        bus.HRDATA    = 32'h0;
        bus.HRESP     = 1'b0;

        repeat (2) @(negedge HCLK);
        check("rst_req_ready", bus.req_ready, 1'b0);
        check("rst_htrans", bus.HTRANS, 2'b00);
        check("rst_haddr", bus.HADDR, 32'h0);
        check("rst_hwdata", bus.HWDATA, 32'h0);
        check("rst_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, 34'h0);
        check("rst_state", dbg_state, 2'd0);
        HRESET = 1'b0;
        #1;
        check("req_ready_pre_edge", bus.req_ready, 1'b0);
        @(negedge HCLK);
        check("req_ready_first_edge", bus.req_ready, 1'b1);

        // w, size, addr, wdata, aw, dw, slave_rd, slave_err, legal, exp_hwdata, exp_rdata, exp_err
        xfer(1, 2'd2, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0,        0, 1, 32'hDEADBEEF, 32'h0,        0);
        xfer(0, 2'd2, 32'h100, 32'h0,        0, 0, 32'hDEADBEEF, 0, 1, 32'h0,        32'hDEADBEEF, 0);
        xfer(0, 2'd0, 32'h103, 32'h0,        0, 0, 32'h11223344, 0, 1, 32'h0,        32'h00000011, 0);
        xfer(1, 2'd0, 32'h102, 32'h123456AB, 0, 0, 32'h0,        0, 1, 32'hABABABAB, 32'h0,        0);
        xfer(1, 2'd1, 32'h102, 32'hFFFFCAFE, 0, 0, 32'h0,        0, 1, 32'hCAFECAFE, 32'h0,        0);
        xfer(0, 2'd1, 32'h102, 32'h0,        0, 0, 32'h11223344, 0, 1, 32'h0,        32'h00001122, 0);
        xfer(0, 2'd0, 32'h101, 32'h0,        0, 0, 32'hA1B2C3D4, 0, 1, 32'h0,        32'h000000C3, 0);
        xfer(1, 2'd2, 32'h200, 32'h0BADF00D, 3, 2, 32'h0,        0, 1, 32'h0BADF00D, 32'h0,        0);
        xfer(1, 2'd2, 32'h204, 32'h01234567, 0, 1, 32'h0,        1, 1, 32'h01234567, 32'h0,        1);
        xfer(0, 2'd1, 32'h101, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        1);
        xfer(1, 2'd3, 32'h100, 32'h55555555, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        1);

        // Reset pulsed during a read's data phase: transfer abandoned, no response.
        wait_ready();
        drive_req(0, 2'd2, 32'h300, 32'h0);
        check("htrans_rst_seq", bus.HTRANS, 2'b10);
        bus.HREADY = 1'b1;
        @(negedge HCLK);
        bus.HREADY = 1'b0;
        @(negedge HCLK);
        check("state_before_rst", dbg_state, 2'd2);
        HRESET        = 1'b1;
        bus.req_valid = 1'b1;
        #1;
        check("midrst_state", dbg_state, 2'd0);
        check("midrst_bus", {bus.HTRANS, bus.HWRITE, bus.HSIZE, bus.HBURST}, 9'h0);
        check("midrst_haddr", bus.HADDR, 32'h0);
        check("midrst_hwdata", bus.HWDATA, 32'h0);
        check("midrst_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, 34'h0);
        check("midrst_req_ready", bus.req_ready, 1'b0);
        @(negedge HCLK);
        check("rst_ignores_req", {bus.req_ready, dbg_state}, 3'b000);
        bus.req_valid = 1'b0;
        bus.HREADY    = 1'b1;
        HRESET        = 1'b0;
        @(negedge HCLK);
        check("req_ready_after_midrst", bus.req_ready, 1'b1);
        xfer(0, 2'd2, 32'h104, 32'h0, 1, 1, 32'h13579BDF, 0, 1, 32'h0, 32'h13579BDF, 0);

        repeat (4) @(negedge HCLK);
        check("queue_empty", exp_q.size(), 0);
        check("pulse_count", n_pulses, n_pushed);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/ahb_lite_master.md
AHB_LITE_MASTER -- requirements
Module: ahb_lite_master

Interface
REQ-001: The block SHALL have parameter ADDR_WIDTH, default 32, giving the HADDR and req_addr width.
REQ-002: The block SHALL have parameter DATA_WIDTH, fixed at 32, giving the HWDATA, HRDATA, req_wdata and rsp_rdata width.
REQ-003: Port HCLK, input, 1 bit: the single clock for the whole block.
REQ-004: Port HRESET, input, 1 bit: reset, asynchronous and active-high.
REQ-005: Port req_valid, input, 1 bit: a transfer request is present.
REQ-006: Port req_ready, output, 1 bit: the request is accepted this cycle.
REQ-007: Port req_write, input, 1 bit: 1 = write, 0 = read.
REQ-008: Port req_size, input, 2 bits: 0 = byte, 1 = halfword, 2 = word; 3 is illegal.
REQ-009: Port req_addr, input, ADDR_WIDTH bits: byte address.
REQ-010: Port req_wdata, input, 32 bits: write data, right-aligned in the LSBs.
REQ-011: Port rsp_valid, output, 1 bit: one-cycle completion pulse.
REQ-012: Port rsp_rdata, output, 32 bits: read data, right-aligned and zero-extended.
REQ-013: Port rsp_err, output, 1 bit: the transfer errored; valid with rsp_valid.
REQ-014: The AHB-Lite outputs SHALL be HADDR (ADDR_WIDTH), HTRANS (2), HWRITE (1), HSIZE (3), HBURST (3) and HWDATA (32).
REQ-015: The AHB-Lite inputs SHALL be HREADY (1), HRDATA (32) and HRESP (1).

Function
REQ-016: States SHALL be IDLE, ADDR, DATA and RESP.
- Exactly one transfer is outstanding at a time.
- The state and all outputs are registered.
REQ-017: req_ready SHALL equal 1 only in IDLE; a request is accepted on the edge where req_valid and req_ready are both 1.
REQ-018: A legal request SHALL be accepted as follows.
- Latch addr, size, write and wdata.
- Go to ADDR.
- Legal means req_size is not 3 and addr is aligned: halfword needs addr[0]=0, word needs addr[1:0]=0.
REQ-019: An illegal request SHALL still be accepted, go directly to RESP, and cause no bus activity; rsp_err=1 and rsp_rdata=0.
REQ-020: In ADDR the block SHALL drive the following.
- HTRANS=NONSEQ (2'b10), HBURST=SINGLE (3'b000).
- HSIZE = {1'b0, size}, HADDR = the latched address, HWRITE = the latched write bit.
REQ-021: ADDR SHALL hold all address-phase signals stable while HREADY=0, and go to DATA on the first cycle with HREADY=1.
REQ-022: In DATA the block SHALL drive HTRANS=IDLE (2'b00).
- For a write, HWDATA = wdata lanes replicated.
- Byte: {4{wdata[7:0]}}. Halfword: {2{wdata[15:0]}}. Word: wdata.
- HWDATA is held stable until HREADY=1.
REQ-023: DATA SHALL complete on the first cycle with HREADY=1.
- Capture HRESP into rsp_err.
- For a read, capture HRDATA shifted right by 8*addr[1:0], masked to the access size, zero-extended. Writes return rsp_rdata=0.
- Go to RESP.
REQ-024: An HRESP=1 seen with HREADY=0 SHALL NOT end DATA; only the HREADY=1 cycle of a two-cycle error response completes the transfer.
REQ-025: RESP SHALL assert rsp_valid=1 for exactly one cycle, then go to IDLE; rsp_rdata and rsp_err hold their value until the next RESP.
- Back-to-back transfers therefore take at least 4 cycles each.
REQ-026: Outside ADDR the block SHALL drive HTRANS=IDLE, never BUSY or SEQ.
- Outside DATA-with-write, HWDATA holds its last value.
REQ-027: Request inputs SHALL be ignored outside IDLE.

Reset
REQ-028: While HRESET=1 the block SHALL immediately force the following, independent of HCLK.
- State=IDLE, HTRANS=2'b00.
- HADDR=0, HWRITE=0, HSIZE=0, HBURST=0, HWDATA=0.
- rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0.
REQ-029: req_ready SHALL rise on the first HCLK edge after HRESET deasserts.
REQ-030: A reset asserted mid-transfer SHALL abandon that transfer with no rsp_valid.
REQ-031: While HRESET=1, request inputs SHALL be ignored.

Verification
REQ-032: Word write, then word read, at 0x100 with a zero-wait slave.
- Write: HTRANS=NONSEQ for 1 cycle, HWDATA=0xDEADBEEF in the next cycle, rsp_valid 2 cycles after HTRANS.
- Read returns rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-033: Byte read at 0x103 when the slave returns 0x11223344 -> HSIZE=0, rsp_rdata=0x00000011.
- Byte write of 0xAB at 0x102 -> HWDATA=0xABABABAB.
REQ-034: Slave holds HREADY=0 for 3 cycles in the address phase and 2 cycles in the data phase.
- HADDR/HTRANS/HWRITE/HSIZE stay stable throughout; HWDATA stays stable throughout.
- Exactly one rsp_valid pulse occurs.
REQ-035: Two-cycle error response (HREADY=0,HRESP=1 then HREADY=1,HRESP=1) -> rsp_err=1, single rsp_valid pulse, then req_ready=1.
REQ-036: Illegal requests: halfword at 0x101, and req_size=3.
- HTRANS stays IDLE throughout; rsp_err=1, rsp_rdata=0 one cycle after acceptance.
REQ-037: HRESET pulsed during DATA of a read -> outputs go to reset values within the same cycle; no rsp_valid; the next request completes normally.
